// File: rtl/mtr_drv_pwm.sv
// mtr_drv_pwm: dual-motor complementary PWM with dead time, direction pin and one-period coast on reversal.
// Define MTR_DRV_OVR_CURR_EN to add the ovr_i over-current input and sticky fault output.
module mtr_drv_pwm #(
  parameter int PWM_BITS  = 11,
  parameter int DEAD_TIME = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  input  logic        en,
`ifdef MTR_DRV_OVR_CURR_EN
  input  logic        ovr_i,
  output logic        fault,
`endif
  output logic        lft_dir,
  output logic        lft_pwm_a,
  output logic        lft_pwm_b,
  output logic        rght_dir,
  output logic        rght_pwm_a,
  output logic        rght_pwm_b,
  output logic        prd_strt
);
  typedef enum logic {RUN, COAST} state_t;
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
  localparam logic [11:0] MAG_MAX = 12'(CNT_MAX);
  localparam logic [7:0] DT = 8'(DEAD_TIME);
  logic [PWM_BITS-1:0] cnt;
  logic [11:0] spd [2];
  logic load, flt;
  assign load = (cnt == CNT_MAX);
  assign spd[0] = lft_spd;
  assign spd[1] = rght_spd;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      prd_strt <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      prd_strt <= load;
    end
`ifdef MTR_DRV_OVR_CURR_EN
  logic ovr_s1, ovr_s2;
  logic [1:0] ovr_run;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ovr_s1 <= 1'b0;
      ovr_s2 <= 1'b0;
      ovr_run <= '0;
      fault <= 1'b0;
    end else begin
      ovr_s1 <= ovr_i;
      ovr_s2 <= ovr_s1;
      ovr_run <= ovr_s2 ? ((ovr_run == 2'd3) ? ovr_run : ovr_run + 1'b1) : 2'd0;
      fault <= (ovr_s2 && ovr_run == 2'd3) | (fault & ~(load & ~en));
    end
  assign flt = fault;
`else
  assign flt = 1'b0;
`endif
  for (genvar i = 0; i < 2; i++) begin : g_ch
    state_t state, state_nxt;
    logic [PWM_BITS-1:0] duty, mag;
    logic [11:0] abs_spd;
    logic raw, raw_q, rev, dt_ok, dir, pwm_a, pwm_b;
    logic [7:0] dt_cnt;
    assign abs_spd = spd[i][11] ? -spd[i] : spd[i];
    assign mag = (abs_spd > MAG_MAX) ? CNT_MAX : abs_spd[PWM_BITS-1:0];
    assign rev = (mag != '0) && (spd[i][11] != dir);
    assign raw = (cnt < duty);
    assign dt_ok = (dt_cnt == DT);
    always_comb begin
      state_nxt = state;
      if (load) state_nxt = rev ? COAST : RUN;
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= RUN;
      else state <= state_nxt;
    // dt_cnt restarts the cycle after a raw edge, so it is aligned with raw_q, not raw
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        duty <= '0;
        dir <= 1'b0;
        raw_q <= 1'b0;
        dt_cnt <= '0;
        pwm_a <= 1'b0;
        pwm_b <= 1'b0;
      end else begin
        if (load) duty <= mag;
        if (load && mag != '0) dir <= spd[i][11];
        raw_q <= raw;
        dt_cnt <= (raw != raw_q) ? '0 : dt_ok ? dt_cnt : dt_cnt + 1'b1;
        pwm_a <= raw_q & dt_ok & en & (state == RUN) & ~flt;
        pwm_b <= ~raw_q & dt_ok & en & (state == RUN) & ~flt;
      end
  end
  assign lft_dir = g_ch[0].dir;
  assign lft_pwm_a = g_ch[0].pwm_a;
  assign lft_pwm_b = g_ch[0].pwm_b;
  assign rght_dir = g_ch[1].dir;
  assign rght_pwm_a = g_ch[1].pwm_a;
  assign rght_pwm_b = g_ch[1].pwm_b;
endmodule

// File: tb/tb_mtr_drv_pwm.sv
// tb_mtr_drv_pwm: randomized bench with a history-window reference model of the dual-motor PWM driver.
module tb_mtr_drv_pwm;
  localparam int PRD = 2048;
  localparam int DT = 32;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, ovr_i = 1'b0;
  logic [11:0] lft_spd = '0, rght_spd = '0;
  logic lft_dir, lft_pwm_a, lft_pwm_b, rght_dir, rght_pwm_a, rght_pwm_b, prd_strt;
`ifdef MTR_DRV_OVR_CURR_EN
  logic fault;
`endif
  int checks = 0, failures = 0, ncyc = 0, last_ps = -1;
  int c_la, c_lb, c_ra, c_rb;
  int m_pos = 0;
  int m_duty [2] = '{0, 0};
  int hn [2] = '{0, 0};
  bit m_dir [2], m_coast [2], m_rawq [2], e_a [2], e_b [2], e_dir [2];
  bit h [2][DT+1];
  bit o [6];
  bit m_fault = 1'b0, e_prd = 1'b0;

  mtr_drv_pwm #(.PWM_BITS(11), .DEAD_TIME(DT)) dut (
    .clk(clk), .rst_n(rst_n), .lft_spd(lft_spd), .rght_spd(rght_spd), .en(en),
`ifdef MTR_DRV_OVR_CURR_EN
    .ovr_i(ovr_i), .fault(fault),
`endif
    .lft_dir(lft_dir), .lft_pwm_a(lft_pwm_a), .lft_pwm_b(lft_pwm_b),
    .rght_dir(rght_dir), .rght_pwm_a(rght_pwm_a), .rght_pwm_b(rght_pwm_b),
    .prd_strt(prd_strt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Gate drive is legal when the last DT+1 delayed raw samples agree; gates follow one clock later.
  task automatic step();
    int v, mag, ones;
    bit set, stable, gate;
    for (int k = 5; k > 0; k--) o[k] = o[k-1];
    o[0] = ovr_i;
    set = o[2] & o[3] & o[4] & o[5];
    for (int c = 0; c < 2; c++) begin
      for (int k = DT; k > 0; k--) h[c][k] = h[c][k-1];
      h[c][0] = m_rawq[c];
      if (hn[c] <= DT) hn[c]++;
      ones = 0;
      for (int k = 0; k <= DT; k++) ones += int'(h[c][k]);
      stable = (hn[c] == DT + 1) && (ones == 0 || ones == DT + 1);
      gate = en && !m_coast[c] && !m_fault;
      e_a[c] = gate && m_rawq[c] && stable;
      e_b[c] = gate && !m_rawq[c] && stable;
      m_rawq[c] = m_pos < m_duty[c];
      if (m_pos == PRD - 1) begin
        v = (c == 0) ? int'($signed(lft_spd)) : int'($signed(rght_spd));
        mag = (v < 0) ? -v : v;
        if (mag > PRD - 1) mag = PRD - 1;
        m_coast[c] = (mag != 0) && ((v < 0) != m_dir[c]);
        if (mag != 0) m_dir[c] = v < 0;
        m_duty[c] = mag;
      end
      e_dir[c] = m_dir[c];
    end
    if (set) m_fault = 1'b1;
    else if (m_pos == PRD - 1 && !en) m_fault = 1'b0;
    e_prd = m_pos == PRD - 1;
    m_pos = (m_pos + 1) % PRD;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_pos = 0;
      m_fault = 1'b0;
      e_prd = 1'b0;
      for (int c = 0; c < 2; c++) begin
        m_duty[c] = 0; m_dir[c] = 0; m_coast[c] = 0; m_rawq[c] = 0;
        hn[c] = 0; e_a[c] = 0; e_b[c] = 0; e_dir[c] = 0;
      end
      for (int k = 0; k < 6; k++) o[k] = 1'b0;
    end else step();
  end

  initial forever begin
    @(negedge clk);
    ncyc++;
    chk("lft_pwm_a", lft_pwm_a, e_a[0]);
    chk("lft_pwm_b", lft_pwm_b, e_b[0]);
    chk("rght_pwm_a", rght_pwm_a, e_a[1]);
    chk("rght_pwm_b", rght_pwm_b, e_b[1]);
    chk("lft_dir", lft_dir, e_dir[0]);
    chk("rght_dir", rght_dir, e_dir[1]);
    chk("prd_strt", prd_strt, e_prd);
    chk("lft_excl", lft_pwm_a & lft_pwm_b, 0);
    chk("rght_excl", rght_pwm_a & rght_pwm_b, 0);
`ifdef MTR_DRV_OVR_CURR_EN
    chk("fault", fault, m_fault);
`endif
    if (!rst_n) last_ps = -1;
    else if (prd_strt) begin
      if (last_ps >= 0) chk("prd_interval", ncyc - last_ps, PRD);
      last_ps = ncyc;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_prd();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!prd_strt && n < PRD + 50);
    chk("prd_wait", prd_strt, 1);
  endtask

  task automatic measure();
    c_la = 0; c_lb = 0; c_ra = 0; c_rb = 0;
    repeat (PRD) begin
      @(negedge clk);
      c_la += int'(lft_pwm_a); c_lb += int'(lft_pwm_b);
      c_ra += int'(rght_pwm_a); c_rb += int'(rght_pwm_b);
    end
  endtask

  task automatic gates_zero(input string nm);
    chk(nm, {lft_pwm_a, lft_pwm_b, rght_pwm_a, rght_pwm_b}, 0);
  endtask

  function automatic logic [11:0] rnd_spd();
    int k = int'($urandom_range(0, 3));
    if (k == 0) return 12'h800;
    if (k == 1) return 12'($urandom);
    if (k == 2) return 12'($urandom_range(0, 40));
    return 12'(-int'($urandom_range(0, 40)));
  endfunction

  initial begin
    cyc(3);
    chk("rst_outs", {lft_dir, lft_pwm_a, lft_pwm_b, rght_dir, rght_pwm_a, rght_pwm_b, prd_strt}, 0);
    rst_n = 1'b1; en = 1'b1; lft_spd = 12'h400; rght_spd = 12'd300;
    wait_prd(); measure();
    chk("l400_a", c_la, 992); chk("l400_b", c_lb, 992);
    chk("r300_a", c_ra, 268); chk("r300_b", c_rb, 1716);
    chk("l400_dir", lft_dir, 0);
    cyc(700);
    lft_spd = 12'h800; rght_spd = 12'(-300);
    wait_prd(); measure();
    chk("coast_la", c_la, 0); chk("coast_lb", c_lb, 0);
    chk("coast_ra", c_ra, 0); chk("coast_rb", c_rb, 0);
    chk("rev_ldir", lft_dir, 1); chk("rev_rdir", rght_dir, 1);
    measure();
    chk("l800_a", c_la, 2015); chk("l800_b", c_lb, 0);
    chk("rneg_a", c_ra, 268); chk("rneg_b", c_rb, 1716);
    lft_spd = 12'd20; rght_spd = 12'd0;
    wait_prd(); wait_prd(); measure();
    chk("l20_a", c_la, 0); chk("l20_b", c_lb, 1996);
    chk("r0_a", c_ra, 0); chk("r0_b", c_rb, 2048);
    chk("l20_dir", lft_dir, 0); chk("r0_dir_hold", rght_dir, 1);
    lft_spd = 12'd0;
    wait_prd(); measure();
    chk("l0_a", c_la, 0); chk("l0_b", c_lb, 2048); chk("l0_dir", lft_dir, 0);
    lft_spd = 12'h200; rght_spd = 12'h200;
    wait_prd(); wait_prd(); measure();
    chk("l200_a", c_la, 480); chk("l200_b", c_lb, 1504);
    chk("r200_a", c_ra, 480); chk("r200_b", c_rb, 1504);
    cyc(100); en = 1'b0; cyc(1);
    gates_zero("en_off_gates");
    cyc(300); en = 1'b1; cyc(1);
    chk("en_resume_a", lft_pwm_a, 1);
    repeat (12) begin
      cyc(int'($urandom_range(1, 2047)));
      lft_spd = rnd_spd(); rght_spd = rnd_spd();
      en = ($urandom_range(0, 4) != 0);
    end
    en = 1'b1; lft_spd = 12'h200; rght_spd = 12'h200;
    cyc(int'($urandom_range(1, 2047)));
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {lft_dir, lft_pwm_a, lft_pwm_b, rght_dir, rght_pwm_a, rght_pwm_b, prd_strt}, 0);
    cyc(2); rst_n = 1'b1;
    wait_prd(); wait_prd();
`ifdef MTR_DRV_OVR_CURR_EN
    ovr_i = 1'b1; cyc(3); ovr_i = 1'b0; cyc(10);
    chk("ovr3_nofault", fault, 0);
    ovr_i = 1'b1; cyc(7);
    chk("ovr_fault", fault, 1);
    gates_zero("ovr_gates");
    ovr_i = 1'b0; cyc(100);
    chk("fault_sticky", fault, 1);
    en = 1'b0; cyc(2100); en = 1'b1;
    chk("fault_clear", fault, 0);
    cyc(200);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
